// File: rtl/ps2_mouse_pkg.sv
// Shared state encoding and PS/2 mouse protocol bytes for the mouse sequencer.
package ps2_mouse_pkg;

    typedef enum logic [3:0] {
        IDLE,
        SEND_RESET,
        WAIT_ACK_RESET,
        WAIT_BAT,
        WAIT_ID,
        SEND_ENABLE,
        WAIT_ACK_ENABLE,
        STREAM,
        FAILED
    } state_t;

    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] CMD_ENABLE = 8'hF4;
    localparam logic [7:0] ACK        = 8'hFA;
    localparam logic [7:0] RESEND     = 8'hFE;
    localparam logic [7:0] BAT_OK     = 8'hAA;
    localparam logic [7:0] BAT_FAIL   = 8'hFC;
    localparam logic [7:0] MOUSE_ID   = 8'h00;

    function automatic logic is_wait(input state_t s);
        return (s == WAIT_ACK_RESET) || (s == WAIT_BAT) ||
               (s == WAIT_ID) || (s == WAIT_ACK_ENABLE);
    endfunction

endpackage

// File: rtl/ps2_mouse_packet_asm.sv
// Assembles streamed mouse bytes into aligned 3-byte packets; flags a
// hot-plug BAT/ID pair (AA,00) seen at the start of a packet.
module ps2_mouse_packet_asm
    import ps2_mouse_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        active,
    input  logic [7:0]  rx,
    input  logic        rx_valid,
    input  logic        error,
    input  logic        timeout,
    output logic        packet_valid,
    output logic [23:0] packet_data,
    output logic        hotplug
);

    logic [1:0] idx;
    logic [7:0] b0, b1;

    assign hotplug = active && rx_valid && !error && (idx == 2'd1) &&
                     (b0 == BAT_OK) && (rx == MOUSE_ID);

    always_ff @(posedge clk) begin
        if (reset) begin
            idx          <= 2'd0;
            b0           <= 8'h00;
            b1           <= 8'h00;
            packet_valid <= 1'b0;
            packet_data  <= 24'h0;
        end else begin
            packet_valid <= 1'b0;
            if (!active) begin
                idx <= 2'd0;
            end else if (rx_valid) begin
                if (error) begin
                    idx <= 2'd0;
                end else begin
                    case (idx)
                        2'd0: begin
                            // bit3 is always set in a status byte: use it to resync
                            if (rx[3]) begin
                                b0  <= rx;
                                idx <= 2'd1;
                            end
                        end
                        2'd1: begin
                            if (hotplug) begin
                                idx <= 2'd0;
                            end else begin
                                b1  <= rx;
                                idx <= 2'd2;
                            end
                        end
                        default: begin
                            packet_data  <= {rx, b1, b0};
                            packet_valid <= 1'b1;
                            idx          <= 2'd0;
                        end
                    endcase
                end
            end else if (timeout && idx != 2'd0) begin
                idx <= 2'd0;
            end
        end
    end

endmodule

// File: rtl/ps2_mouse_sequencer.sv
// PS/2 mouse bring-up sequencer (reset, BAT, ID, enable reporting) with bounded
// retries and response timeouts, followed by packet streaming.
module ps2_mouse_sequencer
    import ps2_mouse_pkg::*;
#(
    parameter int clkf        = 50000000,
    parameter int timeout_ms  = 500,
    parameter int max_retries = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  rx,
    input  logic        rx_valid,
    input  logic        error,
    output logic [7:0]  tx,
    output logic        start_tx,
    input  logic        tx_busy,
    output logic        ready,
    output logic        init_failed,
    output logic        packet_valid,
    output logic [23:0] packet_data
);

    localparam int TO = clkf / 1000 * timeout_ms;
    localparam int TW = (TO > 1) ? $clog2(TO) : 1;
    localparam int RW = (max_retries > 0) ? $clog2(max_retries + 1) : 1;

    state_t         state, state_d;
    logic [RW-1:0]  retry_cnt, retry_d;
    logic [TW-1:0]  timer;
    logic           en_q, en_rise;
    logic           expire, timer_run;
    logic           start_d;
    logic [7:0]     tx_d;
    logic           retry_req;
    state_t         retry_tgt;
    logic           rx_ok, hotplug;

    assign en_rise   = enable && !en_q;
    assign rx_ok     = rx_valid && !error;
    assign expire    = (timer == TW'(TO - 1));
    // In STREAM the same timer serves as the inter-byte timeout
    assign timer_run = (is_wait(state) && !tx_busy) || (state == STREAM);

    assign ready       = (state == STREAM);
    assign init_failed = (state == FAILED);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            retry_cnt <= '0;
            timer     <= '0;
            // Starts high so an enable held across reset is not taken as an edge
            en_q      <= 1'b1;
            start_tx  <= 1'b0;
            tx        <= 8'h00;
        end else begin
            state     <= state_d;
            retry_cnt <= retry_d;
            en_q      <= enable;
            start_tx  <= start_d;
            tx        <= tx_d;
            if (state_d != state || rx_valid || expire)
                timer <= '0;
            else if (timer_run)
                timer <= timer + 1'b1;
        end
    end

    always_comb begin
        state_d   = state;
        retry_d   = retry_cnt;
        start_d   = 1'b0;
        tx_d      = tx;
        retry_req = 1'b0;
        retry_tgt = SEND_RESET;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    retry_d = '0;
                    if (en_rise) state_d = SEND_RESET;
                end
                SEND_RESET: if (!tx_busy) begin
                    start_d = 1'b1;
                    tx_d    = CMD_RESET;
                    state_d = WAIT_ACK_RESET;
                end
                WAIT_ACK_RESET: begin
                    if (rx_ok) begin
                        if (rx == ACK) state_d = WAIT_BAT;
                        else if (rx == RESEND) retry_req = 1'b1;
                    end else if (!rx_valid && expire) begin
                        retry_req = 1'b1;
                    end
                end
                WAIT_BAT: begin
                    if (rx_ok) begin
                        if (rx == BAT_OK) state_d = WAIT_ID;
                        else if (rx == BAT_FAIL) retry_req = 1'b1;
                    end else if (!rx_valid && expire) begin
                        retry_req = 1'b1;
                    end
                end
                WAIT_ID: begin
                    if (rx_ok) begin
                        if (rx == MOUSE_ID) state_d = SEND_ENABLE;
                        else retry_req = 1'b1;
                    end else if (!rx_valid && expire) begin
                        retry_req = 1'b1;
                    end
                end
                SEND_ENABLE: if (!tx_busy) begin
                    start_d = 1'b1;
                    tx_d    = CMD_ENABLE;
                    state_d = WAIT_ACK_ENABLE;
                end
                WAIT_ACK_ENABLE: begin
                    if (rx_ok) begin
                        if (rx == ACK) begin
                            state_d = STREAM;
                        end else if (rx == RESEND) begin
                            retry_req = 1'b1;
                            retry_tgt = SEND_ENABLE;
                        end
                    end else if (!rx_valid && expire) begin
                        retry_req = 1'b1;
                    end
                end
                STREAM: if (hotplug) state_d = SEND_ENABLE;
                FAILED: if (en_rise) begin
                    retry_d = '0;
                    state_d = SEND_RESET;
                end
                default: state_d = IDLE;
            endcase
            if (retry_req) begin
                if (retry_cnt == RW'(max_retries)) begin
                    state_d = FAILED;
                end else begin
                    retry_d = retry_cnt + 1'b1;
                    state_d = retry_tgt;
                end
            end
        end
    end

    ps2_mouse_packet_asm u_asm (
        .clk          (clk),
        .reset        (reset),
        .active       (state == STREAM),
        .rx           (rx),
        .rx_valid     (rx_valid),
        .error        (error),
        .timeout      (expire),
        .packet_valid (packet_valid),
        .packet_data  (packet_data),
        .hotplug      (hotplug)
    );

endmodule

// File: tb/tb_ps2_mouse_sequencer.sv
// Directed bench for ps2_mouse_sequencer: bring-up, streaming, retries, timeouts.
module tb_ps2_mouse_sequencer;

    logic        clk = 1'b0;
    logic        reset, enable, rx_valid, error, tx_busy;
    logic [7:0]  rx;
    logic [7:0]  tx;
    logic        start_tx, ready, init_failed, packet_valid;
    logic [23:0] packet_data;

    int          n_chk = 0, n_err = 0;
    int          n_tx = 0, n_pkt = 0;
    logic [7:0]  last_tx = 8'h00;
    logic [23:0] last_pkt = 24'h0;

    always #5 clk = ~clk;

    ps2_mouse_sequencer #(.clkf(1000000), .timeout_ms(1), .max_retries(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .rx           (rx),
        .rx_valid     (rx_valid),
        .error        (error),
        .tx           (tx),
        .start_tx     (start_tx),
        .tx_busy      (tx_busy),
        .ready        (ready),
        .init_failed  (init_failed),
        .packet_valid (packet_valid),
        .packet_data  (packet_data)
    );

    always @(posedge clk) begin
        if (!reset && start_tx) begin
            n_tx++;
            last_tx = tx;
        end
        if (!reset && packet_valid) begin
            n_pkt++;
            last_pkt = packet_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic err);
        @(negedge clk);
        rx = b; rx_valid = 1'b1; error = err;
        @(negedge clk);
        rx_valid = 1'b0; error = 1'b0;
        idle(3);
    endtask

    task automatic wait_tx(input string tag, input int n, input int budget);
        int k = 0;
        while (n_tx < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, n_tx, n);
    endtask

    task automatic bringup(input int base);
        enable = 1'b1;
        wait_tx("bu_ff", base + 1, 20);
        chk("bu_ff_byte", last_tx, 8'hFF);
        send_byte(8'hFA, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'h00, 1'b0);
        wait_tx("bu_f4", base + 2, 20);
        chk("bu_f4_byte", last_tx, 8'hF4);
        send_byte(8'hFA, 1'b0);
        chk("bu_ready", ready, 1);
    endtask

    initial begin
        int k;
        reset = 1'b1; enable = 1'b0; rx = 8'h00; rx_valid = 1'b0;
        error = 1'b0; tx_busy = 1'b0;
        idle(3);
        chk("rst_ready", ready, 0);
        chk("rst_failed", init_failed, 0);
        chk("rst_start", start_tx, 0);
        chk("rst_tx", tx, 0);
        chk("rst_pv", packet_valid, 0);
        chk("rst_pd", packet_data, 0);
        reset = 1'b0;
        idle(2);

        // normal bring-up, exactly two commands
        bringup(0);
        idle(10);
        chk("bu_ntx", n_tx, 2);

        // streaming
        send_byte(8'h08, 1'b0); send_byte(8'h05, 1'b0); send_byte(8'hFB, 1'b0);
        chk("pkt1_n", n_pkt, 1);
        chk("pkt1_d", last_pkt, 24'hFB0508);
        send_byte(8'h07, 1'b0);
        send_byte(8'h09, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
        chk("pkt2_n", n_pkt, 2);
        chk("pkt2_d", last_pkt, 24'h020109);
        chk("pkt2_hold", packet_data, 24'h020109);

        // rx error drops the partial packet
        send_byte(8'h08, 1'b0); send_byte(8'h11, 1'b1);
        send_byte(8'h0A, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
        chk("pkt3_n", n_pkt, 3);
        chk("pkt3_d", last_pkt, 24'h02010A);

        // inter-byte timeout drops a stale first byte
        send_byte(8'h08, 1'b0);
        idle(1100);
        chk("ibt_ready", ready, 1);
        send_byte(8'h0C, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
        chk("pkt4_n", n_pkt, 4);
        chk("pkt4_d", last_pkt, 24'h02010C);

        // hot-plug: AA,00 re-enables reporting, no packet
        send_byte(8'hAA, 1'b0);
        send_byte(8'h00, 1'b0);
        chk("hp_ready_low", ready, 0);
        wait_tx("hp_f4", 3, 20);
        chk("hp_f4_byte", last_tx, 8'hF4);
        send_byte(8'hFA, 1'b0);
        chk("hp_ready", ready, 1);
        chk("hp_npkt", n_pkt, 4);

        // enable low forces IDLE; resend of F4
        enable = 1'b0;
        idle(2);
        chk("dis_ready", ready, 0);
        enable = 1'b1;
        wait_tx("rs_ff", 4, 20);
        send_byte(8'hFA, 1'b0); send_byte(8'hAA, 1'b0); send_byte(8'h00, 1'b0);
        wait_tx("rs_f4", 5, 20);
        send_byte(8'hFE, 1'b0);
        wait_tx("rs_f4_again", 6, 20);
        chk("rs_f4_byte", last_tx, 8'hF4);
        send_byte(8'hFA, 1'b0);
        chk("rs_ready", ready, 1);

        // BAT fail resends FF; reset in WAIT_ID returns to IDLE
        enable = 1'b0; idle(2); enable = 1'b1;
        wait_tx("bat_ff", 7, 20);
        send_byte(8'hFA, 1'b0);
        send_byte(8'hFC, 1'b0);
        wait_tx("bat_ff_again", 8, 20);
        chk("bat_ff_byte", last_tx, 8'hFF);
        send_byte(8'hFA, 1'b0); send_byte(8'hAA, 1'b0);
        reset = 1'b1;
        idle(2);
        chk("mid_rst_ready", ready, 0);
        chk("mid_rst_failed", init_failed, 0);
        chk("mid_rst_start", start_tx, 0);
        chk("mid_rst_tx", tx, 0);
        chk("mid_rst_pd", packet_data, 0);
        reset = 1'b0;
        idle(50);
        chk("mid_rst_no_tx", n_tx, 8);

        // silence: 4 FF total then FAILED
        enable = 1'b0; idle(2); enable = 1'b1;
        wait_tx("to_ff1", 9, 20);
        idle(900);
        chk("to_early", n_tx, 9);
        wait_tx("to_ff2", 10, 300);
        wait_tx("to_ff3", 11, 1200);
        wait_tx("to_ff4", 12, 1200);
        k = 0;
        while (!init_failed && k < 1200) begin
            @(negedge clk);
            k++;
        end
        chk("to_failed", init_failed, 1);
        chk("to_ntx", n_tx, 12);
        chk("to_last_ff", last_tx, 8'hFF);

        // new edge restarts with a fresh retry budget
        enable = 1'b0; idle(2); enable = 1'b1;
        wait_tx("re_ff", 13, 20);
        chk("re_not_failed", init_failed, 0);
        wait_tx("re_ff_retry", 14, 1200);
        chk("re_still_ok", init_failed, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ps2_mouse_sequencer.md
Name: ps2_mouse_sequencer

Overview:
- Hardware sequencer for the PS/2 host serial engine (byte tx/rx with busy/valid/error strobes) when it is wired to a mouse.
- After `enable` it runs the mouse bring-up: reset, BAT check, ID check, enable data reporting. Retries are bounded and every response wait has a timeout.
- It then runs streaming: raw bytes are assembled into aligned 3-byte movement packets for the CPU-facing mouse register block.
- It sits between the PS/2 host engine and that register block, and is the sole driver of the engine's tx port.

Parameters:
- clkf, 50000000, clock frequency in Hz.
- timeout_ms, 500, response/inter-byte timeout in ms. Cycle count TO = clkf/1000*timeout_ms, computed at elaboration.
- max_retries, 3, number of reset-sequence restarts before declaring failure.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  level; rising edge while IDLE or FAILED starts bring-up; low forces IDLE.
- rx  in  8  received byte from host engine.
- rx_valid  in  1  one-cycle strobe, rx valid.
- error  in  1  qualifies rx_valid: parity/framing error.
- tx  out  8  command byte to host engine.
- start_tx  out  1  one-cycle transmit request.
- tx_busy  in  1  host engine transmitting.
- ready  out  1  high while in STREAM.
- init_failed  out  1  high while in FAILED.
- packet_valid  out  1  one-cycle strobe.
- packet_data  out  24  {byte2, byte1, byte0}, byte0 = status/buttons byte.

Behaviour:
- Reset: state IDLE; all outputs 0; retry count 0; timeout counter 0; byte index 0.
- Constants: CMD_RESET=FF, CMD_ENABLE=F4, ACK=FA, RESEND=FE, BAT_OK=AA, BAT_FAIL=FC, MOUSE_ID=00.
- States:
  - IDLE: wait for enable rising edge -> SEND_RESET. Retry count cleared.
  - SEND_RESET / SEND_ENABLE:
    - When tx_busy=0: drive tx=cmd and start_tx=1 for exactly one cycle. Next state WAIT_ACK_RESET / WAIT_ACK_ENABLE.
    - tx holds its value until the next command.
  - WAIT_ACK_RESET: FA -> WAIT_BAT. FE -> SEND_RESET (resend, counts as a retry). Any other byte: ignored.
  - WAIT_BAT: AA -> WAIT_ID. FC -> retry.
  - WAIT_ID: 00 -> SEND_ENABLE. Any other value -> retry.
  - WAIT_ACK_ENABLE: FA -> STREAM. FE -> SEND_ENABLE (counts as a retry).
  - STREAM: packet assembly, below.
  - FAILED: init_failed=1; exit via enable re-edge -> SEND_RESET with retry count cleared.
- Retry action:
  - If retry count == max_retries -> FAILED.
  - Otherwise increment the count and go to SEND_RESET (or the resend target).
- Timeout counter:
  - Cleared on every state entry and on every rx_valid.
  - Counts only while in a WAIT_* state and tx_busy=0.
  - Reaching TO-1 triggers the retry action on the next cycle.
- rx_valid with error=1 in any WAIT_* state: byte discarded, no transition, timer still cleared.
- enable low in any state: IDLE on the next cycle. A start_tx in flight is not cancelled in the host engine.
- Packet assembly (STREAM):
  - Index 0: accept the byte only if bit3=1. Otherwise discard, stay at index 0 (resync).
  - Indices 1 and 2 accept any byte.
  - The third byte sets packet_valid=1 for one cycle, with packet_data updated the same cycle (registered, one cycle after rx_valid). Index returns to 0.
  - packet_data holds its value between strobes.
  - rx error at any index: discard the partial packet, index 0.
  - Inter-byte timeout: index != 0 and no byte for TO cycles -> index 0. No state change.
  - Hot-plug: byte AA at index 0 (bit3=1) is treated as a packet start. If the next byte is 00, abandon the packet and go to SEND_ENABLE, with ready low from that cycle.
- Simultaneous rx_valid and timeout expiry: rx_valid wins; timer cleared.
- Synchronous reset mid-transmit: state returns to IDLE; start_tx is never reasserted until a new enable edge.

Decomposition:
- Package ps2_mouse_pkg:
  - state enum (IDLE, SEND_RESET, WAIT_ACK_RESET, WAIT_BAT, WAIT_ID, SEND_ENABLE, WAIT_ACK_ENABLE, STREAM, FAILED);
  - the byte constants above.
- One sub-module, ps2_mouse_packet_asm, containing the index counter, bit3 sync, 24-bit shift/latch and inter-byte timeout. Its inputs are rx/rx_valid/error/active and a timeout pulse from the parent timer.

Test Plan:
Benches use clkf=1000000, timeout_ms=1, so TO=1000.
- Normal bring-up: enable edge -> start_tx with tx=FF; reply FA, AA, 00 -> start_tx with tx=F4; reply FA -> ready=1. No other start_tx.
- Stream packets: feed 08,05,FB -> packet_valid one cycle, packet_data=FB0508. Then feed 07 (bit3=0), 09,01,02 -> single packet 020109; 07 dropped.
- Rx error mid-packet: 08, then 11 with error=1, then 0A,01,02 -> one packet 02010A only.
- Timeouts: no reply to FF -> FF resent after 1000 cycles. Repeated silence -> 4 FF commands total, then init_failed=1. A new enable edge restarts with retry count 0.
- Resend/BAT fail: reply FE to F4 -> F4 resent. Reply FC in WAIT_BAT -> FF resent. Reset asserted during WAIT_ID -> all outputs 0, IDLE.
- Hot-plug in STREAM: AA,00 -> ready drops, F4 transmitted; FA -> ready=1. No packet_valid emitted.
